// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1,
        GAP
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// PicoRV32 native memory bus: valid/ready handshake plus request fields.
interface mem_bus_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Slave-response watchdog: counts unanswered grant cycles, flags expiry,
// and captures the address of the first timed-out transfer.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        s_ready,
    input  logic [31:0] addr,
    input  logic        err_clr,
    output logic        expire,
    output logic        bus_err,
    output logic [31:0] err_addr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = active & ~s_ready & (cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            // idle keeps the count at zero so every grant starts fresh
            if (!active)
                cnt <= '0;
            else if (!s_ready && !expire)
                cnt <= cnt + CW'(1);
            if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end else if (expire && !bus_err) begin
                bus_err  <= 1'b1;
                err_addr <= addr;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native bus.
// Optional watchdog enabled by MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]        grant,
    output logic              bus_err,
    output logic [31:0]       err_addr,
    input  logic              err_clr
);
    state_t state;
    logic   last_grant;
    logic   s_valid_q;
    logic   expire;
    logic   done;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    logic active;
    assign active = (state == GNT0) || (state == GNT1);

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .active  (active),
        .s_ready (s.ready),
        .addr    (s.addr),
        .err_clr (err_clr),
        .expire  (expire),
        .bus_err (bus_err),
        .err_addr(err_addr)
    );
`else
    logic unused_err_clr;
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] unused_tmo;
    assign unused_err_clr = err_clr;
    assign unused_tmo     = '0;
    assign expire         = 1'b0;
    assign bus_err        = 1'b0;
    assign err_addr       = '0;
`endif

    assign done = s.ready | expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= GRANT_NONE;
            last_grant <= 1'b1;
            s_valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // tie goes to whoever was not served last
                    if (m0.valid && (!m1.valid || last_grant)) begin
                        state      <= GNT0;
                        grant      <= GRANT_M0;
                        last_grant <= 1'b0;
                        s_valid_q  <= 1'b1;
                    end else if (m1.valid) begin
                        state      <= GNT1;
                        grant      <= GRANT_M1;
                        last_grant <= 1'b1;
                        s_valid_q  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (done) begin
                        state     <= GAP;
                        grant     <= GRANT_NONE;
                        s_valid_q <= 1'b0;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign s.valid = s_valid_q & ~expire;

    always_comb begin
        s.instr = m0.instr;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
        s.wstrb = m0.wstrb;
        if (grant[1]) begin
            s.instr = m1.instr;
            s.addr  = m1.addr;
            s.wdata = m1.wdata;
            s.wstrb = m1.wstrb;
        end
    end

    always_comb begin
        m0.ready = grant[0] & done;
        m1.ready = grant[1] & done;
        m0.rdata = '0;
        m1.rdata = '0;
        if (grant[0])
            m0.rdata = expire ? ERR_DATA : s.rdata;
        if (grant[1])
            m1.rdata = expire ? ERR_DATA : s.rdata;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, scoreboard,
// contention, reset and watchdog sequences.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        bit          m;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          m;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic [1:0]  grant;
    logic        bus_err;
    logic [31:0] err_addr;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    mem_bus_arbiter_if m0_bus();
    mem_bus_arbiter_if m1_bus();
    mem_bus_arbiter_if s_bus();

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant   (grant),
        .bus_err (bus_err),
        .err_addr(err_addr),
        .err_clr (err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic set_master(input bit m, input logic v,
                              input logic ins, input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [3:0] ws);
        if (!m) begin
            m0_bus.valid = v; m0_bus.instr = ins; m0_bus.addr = a;
            m0_bus.wdata = wd; m0_bus.wstrb = ws;
        end else begin
            m1_bus.valid = v; m1_bus.instr = ins; m1_bus.addr = a;
            m1_bus.wdata = wd; m1_bus.wstrb = ws;
        end
    endtask

    function automatic logic mready(input bit m);
        return m ? m1_bus.ready : m0_bus.ready;
    endfunction

    function automatic logic [31:0] mrdata(input bit m);
        return m ? m1_bus.rdata : m0_bus.rdata;
    endfunction

    function automatic logic [1:0] gnt_of(input bit m);
        return m ? 2'b10 : 2'b01;
    endfunction

    task automatic check_completion();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_empty: got completion want none");
            return;
        end
        e = sb.pop_front();
        chk("cmp_grant", grant, gnt_of(e.m));
        chk("cmp_s_addr", s_bus.addr, e.addr);
        chk("cmp_s_wdata", s_bus.wdata, e.wdata);
        chk("cmp_s_wstrb", s_bus.wstrb, e.wstrb);
        chk("cmp_s_instr", s_bus.instr, e.instr);
        chk("cmp_ready", mready(e.m), 1);
        chk("cmp_rdata", mrdata(e.m), e.rdata);
        chk("cmp_other_ready", mready(!e.m), 0);
        chk("cmp_other_rdata", mrdata(!e.m), 0);
    endtask

    // called one step after a posedge with the arbiter in IDLE
    task automatic run_xfer(input vec_t v);
        exp_t e;
        e = '{v.m, v.instr, v.addr, v.wdata, v.wstrb, v.rdata};
        sb.push_back(e);
        set_master(v.m, 1, v.instr, v.addr, v.wdata, v.wstrb);
        s_bus.rdata = v.rdata;
        @(negedge clk);
        chk("arb_idle_svalid", s_bus.valid, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= v.lat; k++) begin
            if (k == v.lat) s_bus.ready = 1'b1;
            @(negedge clk);
            if (k == 1) chk("grant_latency", grant, gnt_of(v.m));
            if (k < v.lat) begin
                chk("wait_ready", mready(v.m), 0);
                @(posedge clk); #1;
            end else begin
                check_completion();
            end
        end
        @(posedge clk); #1;
        s_bus.ready = 1'b0;
        set_master(v.m, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("gap_svalid", s_bus.valid, 0);
        chk("gap_grant", grant, 0);
        @(posedge clk); #1;
    endtask

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    task automatic timeout_xfer(input bit m, input logic [31:0] a);
        set_master(m, 1, 0, a, 0, 0);
        s_bus.ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("to_wait", mready(m), 0);
                chk("to_wait_svalid", s_bus.valid, 1);
                @(posedge clk); #1;
            end else begin
                chk("to_ready", mready(m), 1);
                chk("to_rdata", mrdata(m), 32'hDEAD_BEEF);
                chk("to_svalid", s_bus.valid, 0);
            end
        end
        @(posedge clk); #1;
        set_master(m, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to_gap_grant", grant, 0);
        @(posedge clk); #1;
    endtask
`endif

    vec_t vecs[7];
    vec_t silent;

    initial begin
        int   cyc;
        int   last_m;
        int   done_cnt[2];
        bit   prev_done;
        exp_t e;
        logic [31:0] a;

        set_master(0, 0, 0, 0, 0, 0);
        set_master(1, 0, 0, 0, 0, 0);
        s_bus.ready = 1'b0;
        s_bus.rdata = '0;

        vecs[0] = '{0, 0, 32'h0000_2004, 32'h0, 4'h0, 2, 32'h1234_5678};
        vecs[1] = '{1, 0, 32'h0200_0000, 32'hAABB_CCDD, 4'b0011, 1,
                    32'h0};
        vecs[2] = '{0, 1, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_0013};
        vecs[3] = '{1, 0, 32'h0300_0010, 32'h0, 4'h0, 3, 32'hCAFE_F00D};
        vecs[4] = '{0, 0, 32'h0200_0004, 32'h1122_3344, 4'hF, 1, 32'h0};
        vecs[5] = '{1, 1, 32'hFFFF_FFFC, 32'h0, 4'h0, 4, 32'hFFFF_FFFF};
        vecs[6] = '{0, 0, 32'h0000_0040, 32'h0, 4'h0, 8, 32'h0BAD_CAFE};

        #2;
        chk("rst_grant", grant, 0);
        chk("rst_svalid", s_bus.valid, 0);
        chk("rst_m0_ready", m0_bus.ready, 0);
        chk("rst_m1_ready", m1_bus.ready, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_err_addr", err_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_xfer(vecs[i]);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        timeout_xfer(0, 32'h0300_0000);
        chk("to_bus_err", bus_err, 1);
        chk("to_err_addr", err_addr, 32'h0300_0000);
        timeout_xfer(1, 32'h0400_0000);
        chk("to2_bus_err", bus_err, 1);
        chk("to2_err_addr", err_addr, 32'h0300_0000);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_bus_err", bus_err, 0);
        chk("clr_err_addr", err_addr, 0);
        @(posedge clk); #1;
`else
        silent = '{0, 0, 32'h0300_0000, 32'h0, 4'h0, 1001, 32'h600D_F00D};
        run_xfer(silent);
        chk("silent_bus_err", bus_err, 0);
        chk("silent_err_addr", err_addr, 0);
`endif

        // reset while m1 owns the bus
        set_master(1, 1, 0, 32'h0200_0008, 32'h1, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        chk("mid_grant", grant, 2'b10);
        s_bus.ready = 1'b1;
        #1;
        chk("mid_m1_ready", m1_bus.ready, 1);
        reset = 1'b1;
        #1;
        chk("arst_svalid", s_bus.valid, 0);
        chk("arst_grant", grant, 0);
        chk("arst_m1_ready", m1_bus.ready, 0);
        chk("arst_m0_ready", m0_bus.ready, 0);
        chk("arst_bus_err", bus_err, 0);
        s_bus.ready = 1'b0;
        set_master(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // contention: tie after reset goes to m0, then strict alternation
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_1000 + 32'(4 * i);
            e = '{0, 0, a, 32'h0, 4'h0, a ^ 32'h5A5A_5A5A};
            sb.push_back(e);
            a = 32'h0400_0000 + 32'(4 * i);
            e = '{1, 0, a, ~a, 4'hF, a ^ 32'h5A5A_5A5A};
            sb.push_back(e);
        end
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        last_m = -1;
        prev_done = 0;
        cyc = 0;
        @(posedge clk); #1;
        set_master(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0);
        set_master(1, 1, 0, 32'h0400_0000, ~32'h0400_0000, 4'hF);
        while ((done_cnt[0] < 4 || done_cnt[1] < 4) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (last_m == 0) begin
                a = 32'h0000_1000 + 32'(4 * done_cnt[0]);
                set_master(0, done_cnt[0] < 4, 0, a, 32'h0, 4'h0);
            end else if (last_m == 1) begin
                a = 32'h0400_0000 + 32'(4 * done_cnt[1]);
                set_master(1, done_cnt[1] < 4, 0, a, ~a, 4'hF);
            end
            last_m = -1;
            s_bus.ready = s_bus.valid;
            s_bus.rdata = s_bus.addr ^ 32'h5A5A_5A5A;
            @(negedge clk);
            if (s_bus.ready) begin
                last_m = grant[1] ? 1 : 0;
                check_completion();
                done_cnt[last_m]++;
                prev_done = 1;
            end else if (prev_done) begin
                chk("cont_gap_svalid", s_bus.valid, 0);
                chk("cont_gap_grant", grant, 0);
                prev_done = 0;
            end
        end
        chk("cont_done", done_cnt[0] + done_cnt[1], 8);
        chk("cont_cycles", cyc, 22);
        chk("cont_sb_left", sb.size(), 0);
        @(posedge clk); #1;
        s_bus.ready = 1'b0;
        set_master(0, 0, 0, 0, 0, 0);
        set_master(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cont_end_svalid", s_bus.valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master round-robin arbiter that shares the single PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, rdata) between the CPU (master 0) and a second master such as a DMA or debug engine (master 1). It sits between the masters and the address decoder/slave mux that generates the ROM, RAM, LED and UART ready/rdata. It also provides an optional watchdog that terminates transfers to unmapped or hung addresses.

## Interface
- TIMEOUT_CYCLES, 255: slave-response cycles before forced completion; range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on a timed-out transfer.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_valid, m1_valid  in  1  master request, held until the matching ready.
- m0_instr, m1_instr  in  1  instruction fetch flag.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte enables; 0 means read.
- m0_ready, m1_ready  out  1  transfer complete, one-cycle pulse.
- m0_rdata, m1_rdata  out  32  read data, valid while ready is high.
- s_valid  out  1  request to the slave side.
- s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  fields of the granted master.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot owner; 00 when idle.
- bus_err  out  1  sticky timeout flag.
- err_addr  out  32  address of the first timed-out transfer.
- err_clr  in  1  clears bus_err and err_addr.

## Operation
- FSM states: IDLE, GNT0, GNT1, GAP.
- IDLE:
  - only m0_valid → GNT0; only m1_valid → GNT1.
  - both requesting → grant the master not recorded in last_grant.
  - last_grant updates on each grant; reset value 1, so the CPU wins the first tie.
- GNTx:
  - s_valid = 1; s_* fields driven combinationally from master x.
  - mx_ready = s_ready; mx_rdata = s_rdata.
  - On s_ready → GAP.
- GAP: one mandatory cycle with s_valid = 0 and no grant, so stale valid/ready from the finishing master and the registered slave readies settle. Then → IDLE.
- The non-granted master always sees ready = 0 and rdata = 0.
- A master dropping valid while granted is a protocol violation; the arbiter keeps the grant until completion.
- err_clr has priority over a capture in the same cycle.
- Reset mid-transfer:
  - State returns to IDLE and s_valid deasserts immediately (async).
  - All readies = 0, grant = 00, last_grant = 1, bus_err = 0, err_addr = 0, counter = 0.

## Timing
- Request sampled in IDLE; s_valid asserts the following cycle, i.e. 1 cycle of arbitration latency.
- Completion is combinational: mx_ready follows s_ready in the same cycle.
- Minimum transfer period per master: IDLE + GNT + GAP = 3 cycles for a 1-cycle slave.
- Back-to-back contention alternates the masters. Fairness bound: a requester waits at most one full transfer of the other master plus GAP.
- All outputs are zero while reset is high, except s_* data fields, which are don't-care while s_valid = 0.

## Configuration
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering GNTx and increments each GNTx cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES−1 with no s_ready, the arbiter forces mx_ready = 1 and mx_rdata = ERR_DATA for that cycle.
  - s_valid is held low in that cycle; state → GAP.
  - If bus_err was 0, it sets bus_err = 1 and captures err_addr = s_addr.
  - A timed-out write is dropped.
- Undefined:
  - No counter; a transfer waits indefinitely for s_ready.
  - bus_err and err_addr are tied to 0; err_clr is ignored.

## Structure
- Package mem_bus_arbiter_pkg holds:
  - the state enum (IDLE, GNT0, GNT1, GAP);
  - the default ERR_DATA;
  - GRANT_NONE/GRANT_M0/GRANT_M1 constants.
- Sub-module bus_watchdog holds the counter, expiry compare and error capture. It is instantiated only under MEM_BUS_ARBITER_TIMEOUT_EN.
- The arbiter FSM, round-robin pointer and muxes stay in the top module.

## Test plan
- Single read: m0 read of 32'h0000_2004, slave answers after 2 cycles with 32'h1234_5678 → grant = 01 one cycle after valid; m0_rdata = 32'h1234_5678 with m0_ready; GAP follows.
- Contention: m0 and m1 raise valid in the same cycle, 4 transfers each → grants m0, m1, m0, m1, …; every GAP has s_valid = 0.
- Write pass-through: m1 writes 32'hAABB_CCDD with wstrb 4'b0011 to 32'h0200_0000 → s_wstrb = 0011, s_wdata exact, m0_ready stays 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): m0 reads 32'h0300_0000 with s_ready never asserted → m0_ready after 8 grant cycles, rdata = 32'hDEAD_BEEF, bus_err = 1, err_addr = 32'h0300_0000. A second timeout does not change err_addr; err_clr zeroes both.
- Reset mid-transfer: assert reset during GNT1 → s_valid, grant and readies drop asynchronously. After release, a tie is granted to m0.
- Macro undefined: slave silent for 1000 cycles → no ready, bus_err = 0; a late s_ready completes the transfer normally.
